// File: rtl/pipe_ctrl.sv
// pipe_ctrl: decode-stage register scoreboard with RAW/WAW stall and branch flush sequencing
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MAX_INFLIGHT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_id_valid,
  input  logic [4:0]  i_id_rs1,
  input  logic [4:0]  i_id_rs2,
  input  logic        i_id_rs1_used,
  input  logic        i_id_rs2_used,
  input  logic [4:0]  i_id_rd,
  input  logic        i_id_rd_we,
  input  logic        i_ex_stall,
  input  logic        i_branch_flush,
  input  logic        i_wb_valid,
  input  logic [4:0]  i_wb_rd,
  output logic        o_issue,
  output logic        o_id_stall,
  output logic        o_if_stall,
  output logic        o_flush_if,
  output logic        o_busy,
  output logic [15:0] o_stall_cnt
);
  typedef enum logic {RUN, FLUSH} state_t;
  state_t state, state_n;
  logic [2:0] fcnt, fcnt_n;
  logic [31:0][1:0] pend;
  logic haz;
  // pend[0] is held at zero by reset and never updated, so x0 never hazards
  assign haz = (i_id_rs1_used & (pend[i_id_rs1] != 2'd0)) |
               (i_id_rs2_used & (pend[i_id_rs2] != 2'd0)) |
               (i_id_rd_we & (i_id_rd != 5'd0) & (pend[i_id_rd] == 2'(MAX_INFLIGHT)));
  always_comb begin
    state_n = state;
    fcnt_n = fcnt;
    o_issue = 1'b0;
    o_flush_if = 1'b0;
    if (state == RUN) begin
      o_issue = i_id_valid & ~haz & ~i_ex_stall;
      o_flush_if = i_branch_flush & o_issue;
      if (o_flush_if && FLUSH_CYCLES > 1) begin
        state_n = FLUSH;
        fcnt_n = 3'(FLUSH_CYCLES - 1);
      end
    end else begin
      o_flush_if = 1'b1;
      fcnt_n = fcnt - 3'd1;
      state_n = (fcnt <= 3'd1) ? RUN : FLUSH;
    end
  end
  assign o_id_stall = i_id_valid & ~o_issue & (state == RUN);
  assign o_if_stall = o_id_stall;
  assign o_busy = |pend;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      fcnt <= 3'd0;
      pend <= '0;
      o_stall_cnt <= 16'd0;
    end else begin
      state <= state_n;
      fcnt <= fcnt_n;
      if (o_id_stall && o_stall_cnt != 16'hFFFF) o_stall_cnt <= o_stall_cnt + 16'd1;
      for (int r = 1; r < 32; r++) begin
        if (o_issue && i_id_rd_we && i_id_rd == 5'(r) && !(i_wb_valid && i_wb_rd == 5'(r)))
          pend[r] <= pend[r] + 2'd1;
        else if (i_wb_valid && i_wb_rd == 5'(r) && !(o_issue && i_id_rd_we && i_id_rd == 5'(r)) && pend[r] != 2'd0)
          pend[r] <= pend[r] - 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and random stimulus against an abstract scoreboard model, checked by a queue-driven monitor
module tb_pipe_ctrl;
  localparam int FC = 2;
  localparam int MI = 3;
  logic clk = 0, rst_n = 0;
  logic id_valid = 0, rs1_used = 0, rs2_used = 0, rd_we = 0, ex_stall = 0, branch = 0, wb_valid = 0;
  logic [4:0] rs1 = 0, rs2 = 0, rd = 0, wb_rd = 0;
  logic issue, id_stall, if_stall, flush_if, busy;
  logic [15:0] stall_cnt;
  typedef struct {logic issue, id_stall, flush_if, busy; logic [15:0] cnt;} exp_t;
  exp_t q[$];
  int tests = 0, fails = 0;
  int pm[32];
  int flush_rem = 0, scnt = 0;
  pipe_ctrl #(.FLUSH_CYCLES(FC), .MAX_INFLIGHT(MI)) dut (
    .clk(clk), .rst_n(rst_n), .i_id_valid(id_valid), .i_id_rs1(rs1), .i_id_rs2(rs2),
    .i_id_rs1_used(rs1_used), .i_id_rs2_used(rs2_used), .i_id_rd(rd), .i_id_rd_we(rd_we),
    .i_ex_stall(ex_stall), .i_branch_flush(branch), .i_wb_valid(wb_valid), .i_wb_rd(wb_rd),
    .o_issue(issue), .o_id_stall(id_stall), .o_if_stall(if_stall), .o_flush_if(flush_if),
    .o_busy(busy), .o_stall_cnt(stall_cnt));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", n, a, e, $time);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("issue", 16'(issue), 16'(e.issue));
      chk("id_stall", 16'(id_stall), 16'(e.id_stall));
      chk("if_stall", 16'(if_stall), 16'(e.id_stall));
      chk("flush_if", 16'(flush_if), 16'(e.flush_if));
      chk("busy", 16'(busy), 16'(e.busy));
      chk("stall_cnt", stall_cnt, e.cnt);
    end
  end
  task automatic model_reset();
    foreach (pm[i]) pm[i] = 0;
    flush_rem = 0;
    scnt = 0;
  endtask
  task automatic cyc(input bit v, input bit [4:0] r1, input bit u1, input bit [4:0] r2, input bit u2,
                     input bit [4:0] d, input bit we, input bit ex, input bit br,
                     input bit wv, input bit [4:0] wr, input bit rst = 1);
    exp_t e;
    bit haz, iss, flushing, any;
    id_valid = v; rs1 = r1; rs1_used = u1; rs2 = r2; rs2_used = u2; rd = d; rd_we = we;
    ex_stall = ex; branch = br; wb_valid = wv; wb_rd = wr; rst_n = rst;
    flushing = flush_rem > 0;
    haz = (u1 && pm[r1] > 0) || (u2 && pm[r2] > 0) || (we && d != 0 && pm[d] >= MI);
    iss = !flushing && v && !haz && !ex;
    any = 0;
    foreach (pm[i]) if (pm[i] > 0) any = 1;
    e.issue = iss;
    e.id_stall = v && !iss && !flushing;
    e.flush_if = flushing || (br && iss);
    e.busy = any;
    e.cnt = 16'(scnt);
    q.push_back(e);
    @(posedge clk);
    if (!rst) model_reset();
    else begin
      if (e.id_stall && scnt < 65535) scnt++;
      if (flushing) flush_rem--;
      else if (br && iss) flush_rem = FC - 1;
      if (!(iss && we && d != 0 && wv && wr == d)) begin
        if (iss && we && d != 0) pm[d]++;
        if (wv && wr != 0 && pm[wr] > 0) pm[wr]--;
      end
    end
    #1;
  endtask
  task automatic idle(); cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    cyc(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5);
    idle();
    cyc(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
    cyc(1, 3, 1, 0, 0, 9, 1, 0, 0, 0, 0);
    cyc(1, 3, 1, 0, 0, 9, 1, 0, 0, 0, 0);
    cyc(1, 3, 1, 0, 0, 9, 1, 0, 0, 1, 3);
    cyc(1, 3, 1, 0, 0, 9, 1, 0, 0, 1, 9);
    idle();
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    idle();
    repeat (4) cyc(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 7, 1, 0, 0, 1, 7);
    cyc(1, 0, 0, 0, 0, 7, 1, 0, 0, 1, 7);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    cyc(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0);
    idle();
    for (int n = 0; n < 3000; n++)
      cyc($urandom_range(0, 9) < 8, 5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
          5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 9) < 5, 5'($urandom_range(0, 7)), $urandom_range(0, 299) != 0);
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain actual=%0d expected=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
